pc_cfg_loader: RTL and testbench

- Initiator for the primitive-converter control port: sel / addr / r_in / r_out / we.
- Turns a simple command stream from the slow-control fabric into correctly timed parameter and theta-LUT accesses.
- Supports write-verify and bulk fill, and returns one response per command.
- One instance per primitive-converter group, in the control_clk domain.

---
 rtl/pc_cfg_pkg.sv | 43 ++++
 rtl/pc_cfg_rd_timer.sv | 39 +++
 rtl/pc_cfg_loader.sv | 254 +++++++++++++++++++++++++
 tb/tb_pc_cfg_loader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_cfg_pkg.sv
// pc_cfg_pkg: types and constants shared by the primitive-converter config loader.
package pc_cfg_pkg;

   // Stored width of one theta-LUT word; only these bits survive a write.
   localparam int PC_TH_W_DEFAULT = 6;

   // The read-latency counter must hold any RD_LAT value from 1 to 7.
   localparam int RD_TIMER_W = 3;

   // Command opcodes as carried on cmd_op.
   typedef enum logic [1:0] {
      OP_WRITE        = 2'd0,
      OP_READ         = 2'd1,
      OP_WRITE_VERIFY = 2'd2,
      OP_FILL         = 2'd3
   } op_e;

   // Target-space codes driven on the converter sel port.
   localparam logic [1:0] SEL_PARAMS = 2'd0;
   localparam logic [1:0] SEL_TH     = 2'd1;
   localparam logic [1:0] SEL_ID     = 2'd2;

   // Loader sequencing states.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR     = 3'd1,
      S_WAIT   = 3'd2,
      S_SAMPLE = 3'd3,
      S_FILL   = 3'd4,
      S_RESP   = 3'd5
   } state_e;

   // Everything except READ modifies converter state.
   function automatic logic is_write_op(input op_e op);
      return (op != OP_READ);
   endfunction

   // Error counter increment that sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pc_cfg_rd_timer.sv
// pc_cfg_rd_timer: loadable down-counter that flags the last cycle of a read wait.
// done is high in the cycle where the counter holds 1, i.e. load_val cycles after load.
module pc_cfg_rd_timer
   import pc_cfg_pkg::*;
#(
   parameter int CNT_W = RD_TIMER_W
) (
   input  logic             control_clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Reload on request, otherwise count down and rest at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge control_clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == CNT_W'(1)) && !load;

endmodule

// File: rtl/pc_cfg_loader.sv
// pc_cfg_loader: turns slow-control commands into timed primitive-converter
// parameter / theta-LUT accesses and returns one response per command.
// Optional build macro PC_CFG_LOADER_ID_CHECK_EN adds a post-reset converter ID check
// (ports expected_id / id_err).
module pc_cfg_loader
   import pc_cfg_pkg::*;
#(
   parameter int BW_ADDR = 7,
   parameter int DW      = 13,
   parameter int TH_W    = PC_TH_W_DEFAULT,
   parameter int RD_LAT  = 2
) (
   input  logic               control_clk,
   input  logic               rst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [1:0]         cmd_sel,
   input  logic [BW_ADDR-1:0] cmd_addr,
   input  logic [DW-1:0]      cmd_data,
   input  logic [BW_ADDR-1:0] cmd_len,
   output logic [1:0]         sel,
   output logic [BW_ADDR-1:0] addr,
   output logic [DW-1:0]      r_in,
   output logic               we,
   input  logic [DW-1:0]      r_out,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_data,
   output logic               rsp_err,
`ifdef PC_CFG_LOADER_ID_CHECK_EN
   input  logic [7:0]         expected_id,
   output logic               id_err,
`endif
   output logic [7:0]         err_cnt
);

   // Theta-LUT readback only carries TH_W meaningful bits.
   localparam logic [DW-1:0]         TH_MASK  = DW'((1 << TH_W) - 1);
   localparam logic [RD_TIMER_W-1:0] RD_LAT_V = RD_TIMER_W'(RD_LAT);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic [1:0]           sel_q, sel_d;
   logic [BW_ADDR-1:0]   addr_q, addr_d;
   logic [DW-1:0]        r_in_q, r_in_d;
   logic                 we_q, we_d;
   logic [BW_ADDR-1:0]   remain_q, remain_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]        rsp_data_q, rsp_data_d;
   logic                 rsp_err_q, rsp_err_d;
   logic [7:0]           err_cnt_q, err_cnt_d;

   op_e                  cmd_op_v;
   logic                 accept;
   logic                 tmr_load;
   logic                 tmr_done;
   logic                 verify_miss;
   logic                 id_pending;
   logic                 id_block;

   assign cmd_op_v = op_e'(cmd_op);
   assign cmd_ready = (state_q == S_IDLE) && !rst && !id_pending;
   assign accept    = cmd_valid && cmd_ready;

   // Readback compare for WRITE_VERIFY: theta words are masked, params compare in full.
   assign verify_miss = (sel_q == SEL_TH) ? (((r_out ^ r_in_q) & TH_MASK) != '0)
                                          : (r_out != r_in_q);

   pc_cfg_rd_timer #(
      .CNT_W      (RD_TIMER_W)
   ) u_rd_timer (
      .control_clk (control_clk),
      .rst         (rst),
      .load        (tmr_load),
      .load_val    (RD_LAT_V),
      .done        (tmr_done)
   );

`ifdef PC_CFG_LOADER_ID_CHECK_EN
   logic id_done_q, id_done_d;
   logic id_err_q, id_err_d;

   // The first SAMPLE after reset belongs to the ID read; a mismatch latches until reset.
   always_comb begin
      id_done_d = id_done_q;
      id_err_d  = id_err_q;
      if (!id_done_q && state_q == S_SAMPLE) begin
         id_done_d = 1'b1;
         id_err_d  = (r_out[7:0] != expected_id);
      end
   end

   // ID check status registers.
   always_ff @(posedge control_clk) begin
      if (rst) begin
         id_done_q <= 1'b0;
         id_err_q  <= 1'b0;
      end else begin
         id_done_q <= id_done_d;
         id_err_q  <= id_err_d;
      end
   end

   assign id_pending = !id_done_q;
   assign id_block   = id_err_q;
   assign id_err     = id_err_q;
`else
   assign id_pending = 1'b0;
   assign id_block   = 1'b0;
`endif

   // Next-state and next-output logic; registered outputs follow the next state so
   // we, sel and addr all change on the same edge and never glitch against each other.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      sel_d      = sel_q;
      addr_d     = addr_q;
      r_in_d     = r_in_q;
      remain_d   = remain_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = 1'b0;
      err_cnt_d  = err_cnt_q;
      tmr_load   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (id_pending) begin
               sel_d    = SEL_ID;
               addr_d   = '0;
               tmr_load = 1'b1;
               state_d  = S_WAIT;
            end else if (accept) begin
               op_d = cmd_op_v;
               if (id_block || (is_write_op(cmd_op_v) && cmd_sel >= SEL_ID)) begin
                  rsp_data_d = '0;
                  rsp_err_d  = 1'b1;
                  state_d    = S_RESP;
               end else if (cmd_op_v == OP_FILL && cmd_len == '0) begin
                  rsp_data_d = '0;
                  state_d    = S_RESP;
               end else begin
                  sel_d    = cmd_sel;
                  addr_d   = cmd_addr;
                  r_in_d   = cmd_data;
                  remain_d = cmd_len;
                  case (cmd_op_v)
                     OP_WRITE, OP_WRITE_VERIFY: state_d = S_WR;
                     OP_READ: begin
                        tmr_load = 1'b1;
                        state_d  = S_WAIT;
                     end
                     OP_FILL: state_d = S_FILL;
                     default: state_d = S_IDLE;
                  endcase
               end
            end
         end

         S_WR: begin
            if (op_q == OP_WRITE_VERIFY) begin
               tmr_load = 1'b1;
               state_d  = S_WAIT;
            end else begin
               state_d = S_RESP;
            end
         end

         S_WAIT: begin
            if (tmr_done) begin
               state_d = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            if (id_pending) begin
               state_d = S_IDLE;
            end else begin
               rsp_data_d = r_out;
               rsp_err_d  = (op_q == OP_WRITE_VERIFY) && verify_miss;
               state_d    = S_RESP;
            end
         end

         S_FILL: begin
            if (remain_q == BW_ADDR'(1)) begin
               rsp_data_d = DW'(addr_q);
               state_d    = S_RESP;
            end else if (addr_q == '1) begin
               rsp_data_d = DW'(addr_q);
               rsp_err_d  = 1'b1;
               state_d    = S_RESP;
            end else begin
               addr_d   = addr_q + BW_ADDR'(1);
               remain_d = remain_q - BW_ADDR'(1);
            end
         end

         S_RESP: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (rsp_err_d) begin
         err_cnt_d = sat_inc8(err_cnt_q);
      end

      we_d        = (state_d == S_WR) || (state_d == S_FILL);
      rsp_valid_d = (state_d == S_RESP);
   end

   // State and output registers; reset drops any in-flight command silently.
   always_ff @(posedge control_clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= OP_WRITE;
         sel_q       <= '0;
         addr_q      <= '0;
         r_in_q      <= '0;
         we_q        <= 1'b0;
         remain_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         r_in_q      <= r_in_d;
         we_q        <= we_d;
         remain_q    <= remain_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign sel       = sel_q;
   assign addr      = addr_q;
   assign r_in      = r_in_q;
   assign we        = we_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pc_cfg_loader.sv
// tb_pc_cfg_loader: directed and randomized checks of pc_cfg_loader against a
// converter model and a command-level reference model.
module tb_pc_cfg_loader;

   localparam int BW_ADDR   = 7;
   localparam int DW        = 13;
   localparam int TH_W      = 6;
   localparam int RD_LAT    = 2;
   localparam int ADDR_SPAN = 1 << BW_ADDR;
   localparam logic [DW-1:0] PC_ID = 13'h0024;

   logic               control_clk = 1'b0;
   logic               rst;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [1:0]         cmd_sel;
   logic [BW_ADDR-1:0] cmd_addr;
   logic [DW-1:0]      cmd_data;
   logic [BW_ADDR-1:0] cmd_len;
   logic [1:0]         sel;
   logic [BW_ADDR-1:0] addr;
   logic [DW-1:0]      r_in;
   logic               we;
   logic [DW-1:0]      r_out;
   logic               rsp_valid;
   logic [DW-1:0]      rsp_data;
   logic               rsp_err;
   logic [7:0]         err_cnt;
`ifdef PC_CFG_LOADER_ID_CHECK_EN
   logic [7:0]         expected_id;
   logic               id_err;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   // Converter model storage (written only by the write monitor).
   logic [DW-1:0]   convParams [ADDR_SPAN];
   logic [TH_W-1:0] convTh     [ADDR_SPAN];
   logic [21:0]     wrLog [$];
   logic            forceThZero = 1'b0;

   // Reference model state (written only by the main stimulus process).
   logic [DW-1:0]   refParams [ADDR_SPAN];
   logic [TH_W-1:0] refTh     [ADDR_SPAN];
   int              refErrCnt;

   always #5 control_clk = ~control_clk;

   pc_cfg_loader #(
      .BW_ADDR (BW_ADDR),
      .DW      (DW),
      .TH_W    (TH_W),
      .RD_LAT  (RD_LAT)
   ) dut (
      .control_clk (control_clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_sel     (cmd_sel),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .cmd_len     (cmd_len),
      .sel         (sel),
      .addr        (addr),
      .r_in        (r_in),
      .we          (we),
      .r_out       (r_out),
      .rsp_valid   (rsp_valid),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
`ifdef PC_CFG_LOADER_ID_CHECK_EN
      .expected_id (expected_id),
      .id_err      (id_err),
`endif
      .err_cnt     (err_cnt)
   );

   function automatic logic [DW-1:0] initParam(input int i);
      return DW'(i * 37 + 5);
   endfunction

   function automatic logic [TH_W-1:0] initTh(input int i);
      return TH_W'(i * 11 + 3);
   endfunction

   // Converter readback is combinational from sel/addr.
   always_comb begin
      r_out = '0;
      case (sel)
         2'd0:    r_out = convParams[addr];
         2'd1:    r_out = forceThZero ? '0 : DW'(convTh[addr]);
         2'd2:    r_out = (addr == '0) ? PC_ID : '0;
         default: r_out = '0;
      endcase
   end

   // Converter write port, sampled mid-cycle; every we cycle is logged.
   initial begin
      for (int i = 0; i < ADDR_SPAN; i++) begin
         convParams[i] = initParam(i);
         convTh[i]     = initTh(i);
      end
      forever begin
         @(negedge control_clk);
         if (we === 1'b1) begin
            wrLog.push_back({sel, addr, r_in});
            if (sel == 2'd0) convParams[addr] = r_in;
            else if (sel == 2'd1) convTh[addr] = r_in[TH_W-1:0];
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [DW-1:0] refRead(input int s, input int a);
      case (s)
         0:       return refParams[a];
         1:       return forceThZero ? '0 : DW'(refTh[a]);
         2:       return (a == 0) ? PC_ID : '0;
         default: return '0;
      endcase
   endfunction

   // Issue one command and wait for its response, measuring cycles from accept.
   task automatic applyStimulus(input int op, input int s, input int a, input int d, input int len,
                                output bit accepted, output int lat, output logic [DW-1:0] rData,
                                output logic rErr, output logic [7:0] rCnt, output logic readyInResp,
                                output logic validAfter);
      accepted = 0; lat = -1; rData = '0; rErr = 1'b0; rCnt = '0;
      readyInResp = 1'bx; validAfter = 1'bx;
      for (int k = 0; k < 50; k++) begin
         @(negedge control_clk);
         if (cmd_ready === 1'b1) begin
            accepted = 1;
            break;
         end
      end
      if (!accepted) return;
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_sel   = 2'(s);
      cmd_addr  = BW_ADDR'(a);
      cmd_data  = DW'(d);
      cmd_len   = BW_ADDR'(len);
      @(negedge control_clk);
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_data  = DW'($urandom);
      for (int k = 1; k <= 300; k++) begin
         if (k > 1) @(negedge control_clk);
         if (rsp_valid === 1'b1) begin
            lat         = k;
            rData       = rsp_data;
            rErr        = rsp_err;
            rCnt        = err_cnt;
            readyInResp = cmd_ready;
            break;
         end
      end
      if (lat < 0) return;
      @(negedge control_clk);
      validAfter = rsp_valid;
   endtask

   // Predict one command from the command rules, run it, and compare everything.
   task automatic runCommand(input int op, input int s, input int a, input int d, input int len);
      logic [21:0]   expWr [$];
      int            expLat;
      logic [DW-1:0] expData;
      logic          expErr;
      bit            chkData;
      int            room, n, logStart;
      bit            accepted;
      int            lat;
      logic [DW-1:0] rData;
      logic          rErr, readyInResp, validAfter;
      logic [7:0]    rCnt;
      logic [DW-1:0] dv;

      dv = DW'(d);
      expWr = {};
      expData = '0;
      expErr = 1'b0;
      chkData = 0;
      expLat = 1;
      if (op != 1 && s >= 2) begin
         expErr = 1'b1;
      end else begin
         case (op)
            0: begin
               expLat = 2;
               expWr.push_back({2'(s), BW_ADDR'(a), dv});
               if (s == 0) refParams[a] = dv; else refTh[a] = dv[TH_W-1:0];
            end
            1: begin
               expLat = RD_LAT + 2;
               chkData = 1;
               expData = refRead(s, a);
            end
            2: begin
               expLat = RD_LAT + 3;
               expWr.push_back({2'(s), BW_ADDR'(a), dv});
               if (s == 0) refParams[a] = dv; else refTh[a] = dv[TH_W-1:0];
               chkData = 1;
               expData = refRead(s, a);
               if (s == 1) expErr = (expData[TH_W-1:0] != dv[TH_W-1:0]);
               else expErr = (expData != dv);
            end
            default: begin
               if (len != 0) begin
                  room = ADDR_SPAN - a;
                  n = (len < room) ? len : room;
                  for (int i = 0; i < n; i++) begin
                     expWr.push_back({2'(s), BW_ADDR'(a + i), dv});
                     if (s == 0) refParams[a + i] = dv; else refTh[a + i] = dv[TH_W-1:0];
                  end
                  expLat = n + 1;
                  chkData = 1;
                  expData = DW'(a + n - 1);
                  expErr = (len > room);
               end
            end
         endcase
      end
      if (expErr && refErrCnt < 255) refErrCnt++;

      logStart = wrLog.size();
      applyStimulus(op, s, a, d, len, accepted, lat, rData, rErr, rCnt, readyInResp, validAfter);
      checkOutput("cmd_accepted", 32'(accepted), 32'd1);
      checkOutput("rsp_latency", 32'(lat), 32'(expLat));
      checkOutput("rsp_err", 32'(rErr), 32'(expErr));
      if (chkData) checkOutput("rsp_data", 32'(rData), 32'(expData));
      checkOutput("err_cnt", 32'(rCnt), 32'(refErrCnt));
      checkOutput("ready_low_in_resp", 32'(readyInResp), 32'd0);
      checkOutput("rsp_one_cycle", 32'(validAfter), 32'd0);
      checkOutput("write_count", 32'(wrLog.size() - logStart), 32'(expWr.size()));
      for (int i = 0; i < expWr.size() && (logStart + i) < wrLog.size(); i++) begin
         checkOutput("write_entry", 32'(wrLog[logStart + i]), 32'(expWr[i]));
      end
   endtask

   initial begin
      int   logStart, rspCount, op, s, a, len;
      bit   seen;
      logic readySeen;

      rst = 1'b1;
      cmd_valid = 1'b0;
      cmd_op = '0;
      cmd_sel = '0;
      cmd_addr = '0;
      cmd_data = '0;
      cmd_len = '0;
`ifdef PC_CFG_LOADER_ID_CHECK_EN
      expected_id = PC_ID[7:0];
`endif
      for (int i = 0; i < ADDR_SPAN; i++) begin
         refParams[i] = initParam(i);
         refTh[i]     = initTh(i);
      end
      refErrCnt = 0;

      // Reset values while reset is held.
      repeat (2) @(posedge control_clk);
      @(negedge control_clk);
      checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd0);
      checkOutput("reset_we", 32'(we), 32'd0);
      checkOutput("reset_sel", 32'(sel), 32'd0);
      checkOutput("reset_addr", 32'(addr), 32'd0);
      checkOutput("reset_r_in", 32'(r_in), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;

      // Directed steps.
      runCommand(0, 0, 1, 'h0123, 0);
      runCommand(0, 1, 5, 'h002A, 0);
      runCommand(1, 1, 5, 0, 0);
      runCommand(1, 0, 1, 0, 0);
      runCommand(2, 1, 3, 'h1FFF, 0);
      forceThZero = 1'b1;
      runCommand(2, 1, 3, 'h1FFF, 0);
      forceThZero = 1'b0;
      runCommand(2, 0, 9, 'h1ABC, 0);
      runCommand(3, 1, 'h7C, 0, 8);
      runCommand(3, 0, 'h7C, 'h0777, 4);
      runCommand(3, 1, 'h20, 'h0011, 0);
      runCommand(0, 2, 4, 'h0055, 0);
      runCommand(3, 3, 0, 'h0055, 3);
      runCommand(1, 2, 0, 0, 0);
      runCommand(3, 0, 'h7F, 'h0101, 1);

      // Randomized commands.
      for (int t = 0; t < 80; t++) begin
         op = $urandom_range(0, 3);
         s = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 3) : $urandom_range(0, 1);
         a = $urandom_range(0, ADDR_SPAN - 1);
         len = $urandom_range(0, 10);
         if (op == 3 && $urandom_range(0, 3) == 0) a = $urandom_range(ADDR_SPAN - 6, ADDR_SPAN - 1);
         runCommand(op, s, a, int'($urandom_range(0, (1 << DW) - 1)), len);
      end

      // Drive the error counter into saturation.
      for (int t = 0; t < 260; t++) begin
         runCommand(0, 2, t % ADDR_SPAN, t, 0);
      end
      checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

      // Reset in the middle of a FILL.
      logStart = wrLog.size();
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge control_clk);
         seen = (cmd_ready === 1'b1);
      end
      checkOutput("ready_before_fill", 32'(seen), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = 2'd3;
      cmd_sel   = 2'd1;
      cmd_addr  = 7'h08;
      cmd_len   = 7'd40;
      cmd_data  = 13'h0015;
      @(negedge control_clk);
      cmd_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         if (we === 1'b1 && addr === 7'h10) begin
            seen = 1;
            break;
         end
         @(negedge control_clk);
      end
      checkOutput("fill_reached_0x10", 32'(seen), 32'd1);
      rst = 1'b1;
      @(negedge control_clk);
      checkOutput("midrst_we", 32'(we), 32'd0);
      checkOutput("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("midrst_sel", 32'(sel), 32'd0);
      checkOutput("midrst_addr", 32'(addr), 32'd0);
      checkOutput("midrst_r_in", 32'(r_in), 32'd0);
      checkOutput("midrst_err_cnt", 32'(err_cnt), 32'd0);
      checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
      rst = 1'b0;
      rspCount = 0;
      readySeen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge control_clk);
         if (rsp_valid === 1'b1) rspCount++;
         if (cmd_ready === 1'b1) readySeen = 1'b1;
      end
      checkOutput("midrst_no_response", 32'(rspCount), 32'd0);
      checkOutput("midrst_ready_after", 32'(readySeen), 32'd1);
      checkOutput("midrst_write_count", 32'(wrLog.size() - logStart), 32'd9);
      for (int i = 8; i <= 16; i++) refTh[i] = 6'h15;
      refErrCnt = 0;
      runCommand(1, 1, 'h10, 0, 0);
      runCommand(1, 1, 'h11, 0, 0);
      runCommand(0, 3, 2, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
